// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data/fetch requesters, the arbiter and the shared memory port.
// Handshake: a requester raises x_req with its fields stable and holds them until the
// one-cycle x_ready pulse; the arbiter holds mem_req with its fields stable until mem_ready.
interface dmem_arbiter_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ctrl;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        err;
  logic        stall_mem;
  logic        stall_fetch;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [1:0]  fsm_state;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, d_ctrl, i_req, i_addr, mem_ready, mem_rdata,
    output d_ready, d_rdata, i_ready, i_rdata, err, stall_mem, stall_fetch,
           mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, fsm_state
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, d_ctrl, i_req, i_addr, mem_ready, mem_rdata,
    input  d_ready, d_rdata, i_ready, i_rdata, err, stall_mem, stall_fetch,
           mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, fsm_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port memory arbiter sharing one port between MEM-stage data accesses and
// instruction fetch, with round-robin on ties, access timeout and pipeline stalls.
module dmem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  // Owner of the current access; between accesses it is the last grant.
  logic        owner_fetch, owner_fetch_n;
  logic        mem_req_q, mem_req_n;
  logic        mem_we_q, mem_we_n;
  logic [31:0] mem_addr_q, mem_addr_n;
  logic [31:0] mem_wdata_q, mem_wdata_n;
  logic [2:0]  mem_ctrl_q, mem_ctrl_n;
  logic        d_ready_q, d_ready_n;
  logic        i_ready_q, i_ready_n;
  logic        err_q, err_n;
  logic [31:0] d_rdata_q, d_rdata_n;
  logic [31:0] i_rdata_q, i_rdata_n;
  logic        pick_fetch;
  logic        timeout_hit;

  assign pick_fetch  = bus.i_req & (~bus.d_req | ~owner_fetch);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      owner_fetch <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ctrl_q  <= 3'b000;
      d_ready_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      owner_fetch <= owner_fetch_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_ctrl_q  <= mem_ctrl_n;
      d_ready_q   <= d_ready_n;
      i_ready_q   <= i_ready_n;
      err_q       <= err_n;
      d_rdata_q   <= d_rdata_n;
      i_rdata_q   <= i_rdata_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    owner_fetch_n = owner_fetch;
    mem_req_n     = mem_req_q;
    mem_we_n      = mem_we_q;
    mem_addr_n    = mem_addr_q;
    mem_wdata_n   = mem_wdata_q;
    mem_ctrl_n    = mem_ctrl_q;
    d_ready_n     = 1'b0;
    i_ready_n     = 1'b0;
    err_n         = 1'b0;
    d_rdata_n     = d_rdata_q;
    i_rdata_n     = i_rdata_q;

    case (state)
      IDLE: begin
        if (bus.d_req || bus.i_req) begin
          state_n       = ACCESS;
          cnt_n         = '0;
          owner_fetch_n = pick_fetch;
          mem_req_n     = 1'b1;
          if (pick_fetch) begin
            mem_we_n    = 1'b0;
            mem_addr_n  = bus.i_addr;
            mem_wdata_n = '0;
            mem_ctrl_n  = 3'b010;
          end else begin
            mem_we_n    = bus.d_we;
            mem_addr_n  = bus.d_addr;
            mem_wdata_n = bus.d_wdata;
            mem_ctrl_n  = bus.d_ctrl;
          end
        end
      end

      ACCESS: begin
        // mem_ready wins over the timeout in the final allowed cycle.
        if (bus.mem_ready) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          d_ready_n = ~owner_fetch;
          i_ready_n = owner_fetch;
          if (!mem_we_q) begin
            if (owner_fetch) i_rdata_n = bus.mem_rdata;
            else             d_rdata_n = bus.mem_rdata;
          end
        end else if (timeout_hit) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          d_ready_n = ~owner_fetch;
          i_ready_n = owner_fetch;
          err_n     = 1'b1;
          if (owner_fetch) i_rdata_n = '0;
          else             d_rdata_n = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CW'(1);
        end
      end

      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_ctrl    = mem_ctrl_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.i_ready     = i_ready_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.err         = err_q;
  assign bus.stall_mem   = bus.d_req & ~d_ready_q;
  assign bus.stall_fetch = bus.i_req & ~i_ready_q;
  assign bus.fsm_state   = state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, contention, load, store, timeout,
// timeout boundary and reset during an access.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  logic        mem_auto;
  int          mem_lat;
  int          req_cycles;

  dmem_arbiter_if bus();

  dmem_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory responder: mem_ready rises mem_lat cycles after mem_req rises (0 = never).
  initial begin
    req_cycles = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) req_cycles++;
      else             req_cycles = 0;
      if (mem_auto) bus.mem_ready = (mem_lat != 0) && (req_cycles == mem_lat + 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({bus.mem_req, bus.mem_we, bus.d_ready, bus.i_ready, bus.err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000", {bus.mem_req, bus.mem_we, bus.d_ready, bus.i_ready, bus.err});
    end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_ctrl} !== 67'h0) begin
      failures++; $display("FAIL reset_mem_fields: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.mem_ctrl});
    end
    checks++; if ({bus.d_rdata, bus.i_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 0", {bus.d_rdata, bus.i_rdata});
    end
    checks++; if (bus.fsm_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d expected 0", bus.fsm_state);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: mem_req got %b expected 0", bus.mem_req);
    end
    tick();
  endtask

  task automatic test_contention();
    logic        is_f;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
    int          k;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_wdata = 32'hAAAA5555;
    bus.d_ctrl = 3'b010; bus.i_req = 1'b1; bus.i_addr = 32'h400; mem_lat = 2;
    for (int t = 0; t < 4; t++) begin
      is_f = t[0];
      exp_rd = 32'h1000_0000 + 32'(t);
      bus.mem_rdata = exp_rd;
      for (k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.mem_req) break;
        tick();
      end
      checks++; if (k == 8) begin
        failures++; $display("FAIL contention_grant_wait turn %0d: no mem_req within 8 cycles", t);
      end
      exp_addr = is_f ? 32'h400 : 32'h300;
      checks++; if (bus.mem_addr !== exp_addr) begin
        failures++; $display("FAIL contention_order turn %0d: mem_addr %h expected %h", t, bus.mem_addr, exp_addr);
      end
      checks++; if (bus.mem_we !== ~is_f) begin
        failures++; $display("FAIL contention_we turn %0d: mem_we %b expected %b", t, bus.mem_we, ~is_f);
      end
      if (is_f) begin
        checks++; if ({bus.mem_wdata, bus.mem_ctrl} !== {32'h0, 3'b010}) begin
          failures++; $display("FAIL contention_fetch_fields turn %0d: wdata %h ctrl %b expected 0/010", t, bus.mem_wdata, bus.mem_ctrl);
        end
      end
      for (k = 0; k < 8; k++) begin
        tick();
        @(negedge clk);
        if (bus.d_ready || bus.i_ready) break;
      end
      checks++; if ({bus.d_ready, bus.i_ready} !== (is_f ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL contention_ready turn %0d: d/i ready %b expected %b", t, {bus.d_ready, bus.i_ready}, (is_f ? 2'b01 : 2'b10));
      end
      if (is_f) begin
        checks++; if (bus.i_rdata !== exp_rd) begin
          failures++; $display("FAIL contention_i_rdata turn %0d: got %h expected %h", t, bus.i_rdata, exp_rd);
        end
      end
      tick();
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0; bus.d_we = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    logic [4:0] e_req, e_stall, e_rdy;
    e_req = 5'b00110; e_stall = 5'b00111; e_rdy = 5'b01000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_ctrl = 3'b010;
    bus.mem_rdata = 32'hDEADBEEF; mem_lat = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({bus.mem_req, bus.stall_mem, bus.d_ready} !== {e_req[c], e_stall[c], e_rdy[c]}) begin
        failures++; $display("FAIL load_cycle%0d: req/stall/ready %b expected %b", c, {bus.mem_req, bus.stall_mem, bus.d_ready}, {e_req[c], e_stall[c], e_rdy[c]});
      end
      if (c == 1) begin
        checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_ctrl} !== {1'b0, 32'h100, 3'b010}) begin
          failures++; $display("FAIL load_fields: we/addr/ctrl %b/%h/%b expected 0/100/010", bus.mem_we, bus.mem_addr, bus.mem_ctrl);
        end
      end
      if (c == 3) begin
        checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin
          failures++; $display("FAIL load_rdata: got %h expected deadbeef", bus.d_rdata);
        end
      end
      tick();
      if (c == 3) bus.d_req = 1'b0;
    end
  endtask

  task automatic test_store();
    logic [4:0] e_req, e_rdy;
    e_req = 5'b00110; e_rdy = 5'b01000;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    bus.d_ctrl = 3'b000; bus.mem_rdata = 32'hCAFEF00D; mem_lat = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({bus.mem_req, bus.d_ready} !== {e_req[c], e_rdy[c]}) begin
        failures++; $display("FAIL store_cycle%0d: req/ready %b expected %b", c, {bus.mem_req, bus.d_ready}, {e_req[c], e_rdy[c]});
      end
      if (c == 1) begin
        checks++; if ({bus.mem_we, bus.mem_wdata, bus.mem_ctrl, bus.mem_addr} !== {1'b1, 32'h12345678, 3'b000, 32'h200}) begin
          failures++; $display("FAIL store_fields: we/wdata/ctrl/addr %b/%h/%b/%h expected 1/12345678/000/200", bus.mem_we, bus.mem_wdata, bus.mem_ctrl, bus.mem_addr);
        end
      end
      if (c == 3) begin
        checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin
          failures++; $display("FAIL store_rdata_hold: got %h expected deadbeef", bus.d_rdata);
        end
      end
      tick();
      if (c == 3) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] e_req, e_rdy;
    e_req = 7'b0011110; e_rdy = 7'b0100000;
    bus.i_req = 1'b1; bus.i_addr = 32'h500; mem_lat = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if ({bus.mem_req, bus.i_ready, bus.err, bus.d_ready} !== {e_req[c], e_rdy[c], e_rdy[c], 1'b0}) begin
        failures++; $display("FAIL timeout_cycle%0d: req/i_ready/err/d_ready %b expected %b", c, {bus.mem_req, bus.i_ready, bus.err, bus.d_ready}, {e_req[c], e_rdy[c], e_rdy[c], 1'b0});
      end
      if (c == 5) begin
        checks++; if (bus.i_rdata !== 32'h0) begin
          failures++; $display("FAIL timeout_rdata: got %h expected 0", bus.i_rdata);
        end
      end
      if (c == 6) begin
        checks++; if (bus.fsm_state !== 2'd0) begin
          failures++; $display("FAIL timeout_idle: state %0d expected 0", bus.fsm_state);
        end
      end
      tick();
      if (c == 5) bus.i_req = 1'b0;
    end
  endtask

  task automatic test_timeout_boundary();
    logic [6:0] e_req, e_rdy;
    e_req = 7'b0011110; e_rdy = 7'b0100000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700; bus.d_ctrl = 3'b010;
    bus.mem_rdata = 32'h0BADF00D; mem_lat = 3;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if ({bus.mem_req, bus.d_ready, bus.err} !== {e_req[c], e_rdy[c], 1'b0}) begin
        failures++; $display("FAIL boundary_cycle%0d: req/d_ready/err %b expected %b", c, {bus.mem_req, bus.d_ready, bus.err}, {e_req[c], e_rdy[c], 1'b0});
      end
      if (c == 5) begin
        checks++; if (bus.d_rdata !== 32'h0BADF00D) begin
          failures++; $display("FAIL boundary_rdata: got %h expected 0badf00d", bus.d_rdata);
        end
      end
      tick();
      if (c == 5) bus.d_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0; bus.mem_ready = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_ctrl = 3'b010;
    bus.i_addr = 32'h800;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) begin
      failures++; $display("FAIL rstmid_access: mem_req %b expected 1", bus.mem_req);
    end
    tick();
    rst = 1'b1; bus.i_req = 1'b1;
    #1;
    checks++; if ({bus.mem_req, bus.fsm_state} !== 3'b000) begin
      failures++; $display("FAIL rstmid_async: mem_req/state %b expected 000", {bus.mem_req, bus.fsm_state});
    end
    @(negedge clk);
    checks++; if ({bus.d_ready, bus.err} !== 2'b00) begin
      failures++; $display("FAIL rstmid_no_pulse: d_ready/err %b expected 00", {bus.d_ready, bus.err});
    end
    tick();
    rst = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.d_ready, bus.err, bus.mem_req} !== 3'b000) begin
      failures++; $display("FAIL rstmid_release: d_ready/err/mem_req %b expected 000", {bus.d_ready, bus.err, bus.mem_req});
    end
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({bus.mem_req, bus.mem_addr, bus.d_ready} !== {1'b1, 32'h600, 1'b0}) begin
      failures++; $display("FAIL rstmid_tie_grant: req/addr/d_ready %b/%h/%b expected 1/600/0", bus.mem_req, bus.mem_addr, bus.d_ready);
    end
    rst = 1'b1; bus.d_req = 1'b0; bus.i_req = 1'b0;
    tick();
    rst = 1'b0; mem_auto = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mem_auto = 1'b1; mem_lat = 1;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_ctrl = '0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_contention();
    test_single_load();
    test_store();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
